oled_spi_sink: RTL and testbench

OLED_SPI_SINK -- requirements
Module: oled_spi_sink

---
 rtl/oled_spi_sink.sv | 210 +++++++++++++++++++++
 tb/tb_oled_spi_sink.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_sink.sv
// Serial sink for an SSD1351-style OLED controller: deserialises the 4-wire SPI stream
// and decodes column/row window commands and RAM writes into a pixel write port.
module oled_spi_sink #(
    parameter int COLS = 128,
    parameter int ROWS = 128
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        OLED_RESb,
    input  logic        OLED_CSb,
    input  logic        OLED_SDCLK,
    input  logic        OLED_SDOUT,
    input  logic        OLED_DCb,
    output logic        pix_we,
    output logic [13:0] pix_addr,
    output logic [15:0] pix_data,
    output logic        cmd_strobe,
    output logic [7:0]  cmd_byte,
    output logic        display_on,
    output logic        abort
);

    // state    | meaning
    // IDLE     | waiting for a command, data bytes ignored
    // PARAM    | collecting the two window parameters of 0x15 / 0x75
    // RAM_HI   | next data byte is pixel[15:8]
    // RAM_LO   | next data byte is pixel[7:0], completes a write
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PARAM  = 2'd1;
    localparam logic [1:0] ST_RAM_HI = 2'd2;
    localparam logic [1:0] ST_RAM_LO = 2'd3;

    localparam logic [6:0] COL_MASK = 7'(COLS - 1);
    localparam logic [6:0] ROW_MASK = 7'(ROWS - 1);

    logic       s_csb;
    logic       s_sdclk;
    logic       s_sdout;
    logic       s_dcb;
    logic       s_resb;
    logic       prev_sdclk;

    logic       soft_rst;
    logic       bit_rise;

    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       byte_vld;
    logic       byte_dc;
    logic [7:0] rx_byte;

    logic [1:0] state;
    logic       param_row;
    logic       param_idx;
    logic [7:0] hi_byte;
    logic [6:0] col_start;
    logic [6:0] col_end;
    logic [6:0] row_start;
    logic [6:0] row_end;
    logic [6:0] col;
    logic [6:0] row;

    logic [6:0] col_param;
    logic [6:0] row_param;

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            s_csb      <= 1'b1;
            s_sdclk    <= 1'b1;
            s_sdout    <= 1'b0;
            s_dcb      <= 1'b0;
            s_resb     <= 1'b0;
            prev_sdclk <= 1'b1;
        end else begin
            s_csb      <= OLED_CSb;
            s_sdclk    <= OLED_SDCLK;
            s_sdout    <= OLED_SDOUT;
            s_dcb      <= OLED_DCb;
            s_resb     <= OLED_RESb;
            prev_sdclk <= s_sdclk;
        end
    end

    assign soft_rst = !RSTb || !s_resb;
    assign bit_rise = s_sdclk && !prev_sdclk && !s_csb;

    // Completed bytes are handed to the decoder one cycle later via rx_byte/byte_vld.
    always_ff @(posedge CLK) begin
        if (soft_rst) begin
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
            byte_vld <= 1'b0;
            byte_dc  <= 1'b0;
            rx_byte  <= 8'h00;
            abort    <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            abort    <= 1'b0;
            if (s_csb) begin
                if (bit_cnt != 3'd0) begin
                    bit_cnt <= 3'd0;
                    shift   <= 8'h00;
                    abort   <= 1'b1;
                end
            end else if (bit_rise) begin
                shift   <= {shift[6:0], s_sdout};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_vld <= 1'b1;
                    byte_dc  <= s_dcb;
                    rx_byte  <= {shift[6:0], s_sdout};
                end
            end
        end
    end

    assign col_param = rx_byte[6:0] & COL_MASK;
    assign row_param = rx_byte[6:0] & ROW_MASK;

    always_ff @(posedge CLK) begin
        if (soft_rst) begin
            state      <= ST_IDLE;
            param_row  <= 1'b0;
            param_idx  <= 1'b0;
            hi_byte    <= 8'h00;
            col_start  <= 7'd0;
            col_end    <= COL_MASK;
            row_start  <= 7'd0;
            row_end    <= ROW_MASK;
            col        <= 7'd0;
            row        <= 7'd0;
            display_on <= 1'b0;
            cmd_byte   <= 8'h00;
            cmd_strobe <= 1'b0;
            pix_we     <= 1'b0;
            pix_addr   <= 14'd0;
            pix_data   <= 16'h0000;
        end else begin
            cmd_strobe <= 1'b0;
            pix_we     <= 1'b0;
            if (byte_vld) begin
                if (!byte_dc) begin
                    cmd_strobe <= 1'b1;
                    cmd_byte   <= rx_byte;
                    param_idx  <= 1'b0;
                    case (rx_byte)
                        8'h15: begin
                            state     <= ST_PARAM;
                            param_row <= 1'b0;
                        end
                        8'h75: begin
                            state     <= ST_PARAM;
                            param_row <= 1'b1;
                        end
                        8'h5C: state <= ST_RAM_HI;
                        8'hAF: begin
                            display_on <= 1'b1;
                            state      <= ST_IDLE;
                        end
                        8'hAE: begin
                            display_on <= 1'b0;
                            state      <= ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end else begin
                    case (state)
                        ST_PARAM: begin
                            if (!param_idx) begin
                                param_idx <= 1'b1;
                                if (param_row) row_start <= row_param;
                                else           col_start <= col_param;
                            end else begin
                                param_idx <= 1'b0;
                                state     <= ST_IDLE;
                                if (param_row) begin
                                    row_end <= row_param;
                                    row     <= row_start;
                                end else begin
                                    col_end <= col_param;
                                    col     <= col_start;
                                end
                            end
                        end
                        ST_RAM_HI: begin
                            hi_byte <= rx_byte;
                            state   <= ST_RAM_LO;
                        end
                        ST_RAM_LO: begin
                            pix_we   <= 1'b1;
                            pix_addr <= {row, col};
                            pix_data <= {hi_byte, rx_byte};
                            state    <= ST_RAM_HI;
                            // Window walk; start>end simply wraps through 0.
                            if (col == col_end) begin
                                col <= col_start;
                                if (row == row_end) row <= row_start;
                                else                row <= (row + 7'd1) & ROW_MASK;
                            end else begin
                                col <= (col + 7'd1) & COL_MASK;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: table of serial bytes with expected decoder
// outputs, plus hand sequences for latency, abort, panel reset and window wrap.
module tb_oled_spi_sink;

    logic        CLK = 1'b0;
    logic        RSTb;
    logic        OLED_RESb;
    logic        OLED_CSb;
    logic        OLED_SDCLK;
    logic        OLED_SDOUT;
    logic        OLED_DCb;
    logic        pix_we;
    logic [13:0] pix_addr;
    logic [15:0] pix_data;
    logic        cmd_strobe;
    logic [7:0]  cmd_byte;
    logic        display_on;
    logic        abort;

    always #5 CLK = ~CLK;

    oled_spi_sink #(.COLS(128), .ROWS(128)) dut (
        .CLK        (CLK),
        .RSTb       (RSTb),
        .OLED_RESb  (OLED_RESb),
        .OLED_CSb   (OLED_CSb),
        .OLED_SDCLK (OLED_SDCLK),
        .OLED_SDOUT (OLED_SDOUT),
        .OLED_DCb   (OLED_DCb),
        .pix_we     (pix_we),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .cmd_strobe (cmd_strobe),
        .cmd_byte   (cmd_byte),
        .display_on (display_on),
        .abort      (abort)
    );

    typedef struct {
        logic        dc;
        logic [7:0]  b;
        int          we;
        logic [13:0] addr;
        logic [15:0] data;
        int          cmd;
        logic [7:0]  cbyte;
        logic        disp;
    } vec_t;

    vec_t vt[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_pix = 0;
    int n_cmd = 0;
    int n_abort = 0;
    logic [13:0] last_addr = '0;
    logic [15:0] last_data = '0;
    logic [7:0]  last_cmd  = '0;
    logic [29:0] pix_log[$];

    // Strobe monitor, sampled 1 time unit after the active edge.
    always @(posedge CLK) begin
        #1;
        if (pix_we) begin
            n_pix++;
            last_addr = pix_addr;
            last_data = pix_data;
            pix_log.push_back({pix_addr, pix_data});
        end
        if (cmd_strobe) begin
            n_cmd++;
            last_cmd = cmd_byte;
        end
        if (abort) n_abort++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic dc, input logic [7:0] b, input int we, input logic [13:0] a,
                       input logic [15:0] d, input int cmd, input logic [7:0] cb, input logic disp);
        vec_t v;
        v.dc = dc; v.b = b; v.we = we; v.addr = a; v.data = d;
        v.cmd = cmd; v.cbyte = cb; v.disp = disp;
        vt.push_back(v);
    endtask

    // Called at a negedge; each bit is one CLK low then one CLK high.
    task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            OLED_SDCLK = 1'b0;
            OLED_SDOUT = b[7-i];
            OLED_DCb   = dc;
            @(negedge CLK);
            OLED_SDCLK = 1'b1;
            @(negedge CLK);
        end
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        send_bits(dc, b, 8);
    endtask

    task automatic sys_reset();
        RSTb       = 1'b0;
        OLED_CSb   = 1'b1;
        OLED_SDCLK = 1'b1;
        repeat (3) @(negedge CLK);
        RSTb = 1'b1;
        repeat (2) @(negedge CLK);
        OLED_CSb = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int p0, c0, a0;
        logic [7:0] lat_byte;

        RSTb       = 1'b0;
        OLED_RESb  = 1'b1;
        OLED_CSb   = 1'b1;
        OLED_SDCLK = 1'b1;
        OLED_SDOUT = 1'b0;
        OLED_DCb   = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_pix_we", 32'(pix_we), 32'd0);
        check("rst_pix_addr", 32'(pix_addr), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_cmd_strobe", 32'(cmd_strobe), 32'd0);
        check("rst_cmd_byte", 32'(cmd_byte), 32'd0);
        check("rst_display_on", 32'(display_on), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        RSTb = 1'b1;
        repeat (2) @(negedge CLK);
        OLED_CSb = 1'b0;
        @(negedge CLK);

        // Strobe latency: final SDCLK rise -> edge E0 -> cmd_strobe visible after E0+2
        lat_byte = 8'hAF;
        send_bits(1'b0, lat_byte, 7);
        OLED_SDCLK = 1'b0;
        OLED_SDOUT = lat_byte[0];
        @(negedge CLK);
        OLED_SDCLK = 1'b1;
        @(negedge CLK);
        check("lat_e0", 32'(cmd_strobe), 32'd0);
        @(negedge CLK);
        check("lat_e1", 32'(cmd_strobe), 32'd0);
        @(negedge CLK);
        check("lat_e2", 32'(cmd_strobe), 32'd1);
        check("lat_cmd_byte", 32'(cmd_byte), 32'hAF);
        check("lat_display_on", 32'(display_on), 32'd1);
        @(negedge CLK);
        check("lat_e3", 32'(cmd_strobe), 32'd0);
        repeat (2) @(negedge CLK);

        // Table: window programming, windowed pixel stream, held-high-byte discard
        add(0, 8'hAF, 0, 14'h000, 16'h0000, 1, 8'hAF, 1);
        add(0, 8'h15, 0, 14'h000, 16'h0000, 1, 8'h15, 1);
        add(1, 8'h02, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(1, 8'h04, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(0, 8'h75, 0, 14'h000, 16'h0000, 1, 8'h75, 1);
        add(1, 8'h10, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(1, 8'h11, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(0, 8'h5C, 0, 14'h000, 16'h0000, 1, 8'h5C, 1);
        add(1, 8'h00, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(1, 8'h01, 1, 14'h802, 16'h0001, 0, 8'h00, 1);
        add(1, 8'h00, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(1, 8'h02, 1, 14'h803, 16'h0002, 0, 8'h00, 1);
        add(1, 8'h00, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(1, 8'h03, 1, 14'h804, 16'h0003, 0, 8'h00, 1);
        add(1, 8'h00, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(1, 8'h04, 1, 14'h882, 16'h0004, 0, 8'h00, 1);
        add(1, 8'h00, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(1, 8'h05, 1, 14'h883, 16'h0005, 0, 8'h00, 1);
        add(1, 8'h00, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(1, 8'h06, 1, 14'h884, 16'h0006, 0, 8'h00, 1);
        add(1, 8'h00, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(1, 8'h07, 1, 14'h802, 16'h0007, 0, 8'h00, 1);
        add(1, 8'h00, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(1, 8'h08, 1, 14'h803, 16'h0008, 0, 8'h00, 1);
        add(1, 8'hAB, 0, 14'h000, 16'h0000, 0, 8'h00, 1);
        add(0, 8'hAE, 0, 14'h000, 16'h0000, 1, 8'hAE, 0);
        add(1, 8'h55, 0, 14'h000, 16'h0000, 0, 8'h00, 0);

        foreach (vt[i]) begin
            p0 = n_pix;
            c0 = n_cmd;
            send_byte(vt[i].dc, vt[i].b);
            repeat (3) @(negedge CLK);
            check($sformatf("vec%0d_pix_cnt", i), 32'(n_pix - p0), 32'(vt[i].we));
            check($sformatf("vec%0d_cmd_cnt", i), 32'(n_cmd - c0), 32'(vt[i].cmd));
            check($sformatf("vec%0d_display_on", i), 32'(display_on), 32'(vt[i].disp));
            if (vt[i].we != 0) begin
                check($sformatf("vec%0d_pix_addr", i), 32'(last_addr), 32'(vt[i].addr));
                check($sformatf("vec%0d_pix_data", i), 32'(last_data), 32'(vt[i].data));
            end
            if (vt[i].cmd != 0)
                check($sformatf("vec%0d_cmd_byte", i), 32'(last_cmd), 32'(vt[i].cbyte));
        end

        // CSb raised mid-byte: one abort, partial byte discarded, RAM_HI kept
        sys_reset();
        send_byte(1'b0, 8'h5C);
        p0 = n_pix;
        a0 = n_abort;
        send_bits(1'b1, 8'hA5, 5);
        OLED_CSb = 1'b1;
        repeat (4) @(negedge CLK);
        check("abort_cnt", 32'(n_abort - a0), 32'd1);
        OLED_CSb = 1'b0;
        @(negedge CLK);
        send_byte(1'b1, 8'hF8);
        send_byte(1'b1, 8'h1F);
        repeat (3) @(negedge CLK);
        check("abort_pix_cnt", 32'(n_pix - p0), 32'd1);
        check("abort_pix_addr", 32'(last_addr), 32'h0000);
        check("abort_pix_data", 32'(last_data), 32'hF81F);
        check("abort_cnt_after", 32'(n_abort - a0), 32'd1);

        // Panel reset mid-pixel after window programming
        send_byte(1'b0, 8'hAF);
        send_byte(1'b0, 8'h15); send_byte(1'b1, 8'h02); send_byte(1'b1, 8'h04);
        send_byte(1'b0, 8'h75); send_byte(1'b1, 8'h10); send_byte(1'b1, 8'h11);
        send_byte(1'b0, 8'h5C);
        p0 = n_pix;
        a0 = n_abort;
        send_byte(1'b1, 8'h12);
        send_bits(1'b1, 8'h34, 4);
        OLED_RESb = 1'b0;
        @(negedge CLK);
        OLED_RESb = 1'b1;
        repeat (3) @(negedge CLK);
        check("resb_pix_cnt", 32'(n_pix - p0), 32'd0);
        check("resb_abort_cnt", 32'(n_abort - a0), 32'd0);
        check("resb_display_on", 32'(display_on), 32'd0);
        check("resb_cmd_byte", 32'(cmd_byte), 32'd0);
        check("resb_pix_addr", 32'(pix_addr), 32'd0);
        send_byte(1'b0, 8'h5C);
        pix_log.delete();
        for (int k = 0; k < 6; k++) begin
            send_byte(1'b1, 8'h01);
            send_byte(1'b1, 8'(k));
        end
        repeat (3) @(negedge CLK);
        check("resb_log_len", 32'(pix_log.size()), 32'd6);
        foreach (pix_log[k])
            check($sformatf("resb_pix%0d", k), 32'(pix_log[k]), 32'({14'(k), 16'h0100 + 16'(k)}));

        // Row window 127..0 over full-width columns: ends at 0x3FFF then wraps to 0
        sys_reset();
        send_byte(1'b0, 8'h75); send_byte(1'b1, 8'h7F); send_byte(1'b1, 8'h00);
        send_byte(1'b0, 8'h5C);
        pix_log.delete();
        for (int k = 0; k < 129; k++) begin
            send_byte(1'b1, 8'(k >> 8));
            send_byte(1'b1, 8'(k));
        end
        repeat (3) @(negedge CLK);
        check("wrap_log_len", 32'(pix_log.size()), 32'd129);
        foreach (pix_log[k])
            check($sformatf("wrap_pix%0d", k), 32'(pix_log[k]),
                  32'({(k < 128) ? 14'h3F80 + 14'(k) : 14'h0000, 16'(k)}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
